clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable integer clock divider that sits directly upstream of the four-phase clock generator and produces its input clock from the system clock. It divides `clk` by a runtime-loadable ratio N, changes ratio only on a period boundary through a request/acknowledge handshake so the output never glitches, and reports lock status. An optional build feature gives 50 % duty cycle for odd ratios.

## Interface
- `WIDTH`, 8: width of the divide ratio.
- `DEF_DIV`, 4: ratio in force after reset; must be 2 to 2^WIDTH-1.
- `clk` in 1: system clock; all logic is on its rising edge, except the optional falling-edge flop.
- `rst` in 1: asynchronous, active-low reset; one clock.
- `en` in 1: divider enable, level.
- `div_val` in WIDTH: requested ratio N; sampled while `div_load`=1.
- `div_load` in 1: load request; held high until `div_ack`.
- `div_ack` out 1: one-cycle pulse; `div_val` has been captured.
- `clk_out` out 1: divided clock; drives the phase generator's `clk`.
- `tick` out 1: one-cycle pulse in the first `clk` cycle of each `clk_out` high phase.
- `locked` out 1: output is running at the committed ratio.

## Operation
- Registers:
  - `ratio` (active N)
  - `shadow` (pending N)
  - `pend` flag
  - counter `cnt` 0..ratio-1
  - registered `clk_out`
- Reset values:
  - `ratio`=DEF_DIV, `shadow`=DEF_DIV, `cnt`=0.
  - `pend`=0, `clk_out`=0, `tick`=0, `div_ack`=0, `locked`=0.
- Ratio clamp: a `div_val` of 0 or 1 is captured as 2. Arithmetic is unsigned, WIDTH bits. The counter never exceeds ratio-1, so there is no wrap overflow.
- High time H = floor(ratio/2). `clk_out` is 1 while `cnt` < H and 0 otherwise.
- States:
  - IDLE: `en`=0. `cnt` is held at 0, `clk_out`=0, `locked`=0.
  - RUN: `cnt` increments each cycle and wraps ratio-1 → 0.
  - PEND: same as RUN with `pend`=1.
- Transitions:
  - IDLE → RUN when `en` is sampled 1.
  - RUN/PEND → IDLE when `en` is sampled 0. This is immediate: `clk_out` is forced 0 next cycle and `cnt` is cleared. A truncated high phase is accepted.
  - RUN → PEND on load capture.
  - PEND → RUN at the wrap edge, where `ratio`←`shadow` and `cnt`←0.
- Load handshake:
  - Capture happens when `div_load`=1 and `pend`=0: `shadow`←clamp(`div_val`), and `div_ack`=1 the next cycle.
  - In IDLE a capture also writes `ratio` directly and does not set `pend`.
  - While `pend`=1, `div_load` is not acknowledged; the request stays pending until the ratio commits.
  - `div_load` deasserted before ack means no capture.
  - At a wrap edge where `ratio` commits, a captured load coincident with that edge is not allowed: `pend` blocks it. The next cycle may capture.
- `locked`:
  - Set at the end of the first complete period after IDLE→RUN or after a ratio commit.
  - Cleared by `en`=0 and by setting `pend`.
- `tick`: 1 in cycles where `cnt`=0 and the state is RUN/PEND.
- Reset mid-operation forces all reset values asynchronously. Any pending ratio is discarded; `ratio` returns to DEF_DIV.

## Timing
- Enable latency: if `en` rises before edge k, edge k leaves `cnt`=0. `clk_out`=1 and `tick`=1 appear from edge k+1, registered.
- Period: exactly `ratio` `clk` cycles. High time is H cycles and low time is ratio-H.
- Ratio change: the new ratio applies from the first period starting after the current one completes. The old period is never shortened.
- Ack latency: 1 cycle when no ratio is pending, otherwise 1 cycle after the commit edge.
- Lock latency: `locked` rises on the edge that ends the first full period at the committed ratio.

## Configuration
- `CLK_DIV_ODD_DUTY_EN` defined:
  - For odd ratios a falling-edge flop delays the high phase by half a cycle.
  - `clk_out` is the OR of the rising- and falling-edge flops, giving high time ratio/2 cycles exactly (50 %).
  - Even ratios are unchanged.
- Not defined: odd ratios have high time floor(N/2) and low time ceil(N/2). No falling-edge logic exists.

## Test plan
- Reset release with `en`=1, no load → `clk_out` 2 high / 2 low (N=4), `tick` every 4 cycles, `locked`=1 after the first 4-cycle period.
- Load `div_val`=6 mid-period at N=4 → `div_ack` 1 cycle later, `locked` drops, current period finishes at 4 cycles, then 3 high / 3 low, `locked` rises after 6 cycles.
- Load `div_val`=1 → captured as 2; output toggles every cycle.
- N=5 without the macro → 2 high / 3 low. With `CLK_DIV_ODD_DUTY_EN` → 2.5 high / 2.5 low, measured on both edges.
- Second `div_load` held while pending → no ack until the commit edge, ack the next cycle; that ratio applies one period later.
- `rst` low during PEND → all outputs 0, ratio back to 4 after release, pending value lost. Separately, `en`=0 mid-high → `clk_out` 0 next cycle, `locked`=0.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// =============================================================================
// Module   : clk_div_prog
// Purpose  : Programmable integer clock divider with period-aligned ratio
//            change handshake, output tick and lock indication.
//            Optional build macro: CLK_DIV_ODD_DUTY_EN (50 % duty for odd N).
// Revision : 1.0
// =============================================================================
module clk_div_prog #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             locked
);

  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_RUN     = 2'd1;
  localparam logic [1:0]       S_PEND    = 2'd2;
  localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             locked_q, locked_d;

  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] clamped;
  logic             wrap;
  logic             capture;
  logic             running;

  assign half    = ratio_q >> 1;
  assign clamped = (div_val < TWO) ? TWO : div_val;
  assign wrap    = (cnt_q == (ratio_q - ONE));
  // The ack cycle also blocks capture so a still-high request is not taken twice.
  assign capture = div_load && !ack_q && (state_q != S_PEND);
  assign running = en && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ratio_q   <= DEF_RATIO;
      shadow_q  <= DEF_RATIO;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ratio_q   <= ratio_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      locked_q  <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en)          state_d = S_IDLE;
        else if (capture) state_d = S_PEND;
      end
      S_PEND: begin
        if (!en)       state_d = S_IDLE;
        else if (wrap) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    ratio_d  = ratio_q;
    cnt_d    = cnt_q;
    if (capture) shadow_d = clamped;
    // Outside a running period there is nothing to protect: commit at once.
    if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
      ratio_d = shadow_d;
    end else if ((state_q == S_PEND) && wrap) begin
      ratio_d = shadow_q;
    end
    if (!running || wrap) cnt_d = '0;
    else                  cnt_d = cnt_q + ONE;
  end

  always_comb begin
    clk_out_d = running && (cnt_q < half);
    tick_d    = running && (cnt_q == '0);
    ack_d     = capture;
    locked_d  = locked_q;
    if (!running || (state_d == S_PEND)) locked_d = 1'b0;
    else if ((state_q == S_RUN) && wrap) locked_d = 1'b1;
  end

  assign div_ack = ack_q;
  assign tick    = tick_q;
  assign locked  = locked_q;

`ifdef CLK_DIV_ODD_DUTY_EN
  logic fall_q;

  // Half-cycle extension of the high phase for odd ratios only.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) fall_q <= 1'b0;
    else      fall_q <= clk_out_q & ratio_q[0];
  end

  assign clk_out = clk_out_q | (fall_q & (state_q != S_IDLE));
`else
  assign clk_out = clk_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// tb_clk_div_prog: randomized ratio loads checked against a period-level model
// built from measured clk_out periods and high times (in half-cycles).
module tb_clk_div_prog;

  localparam int WIDTH = 8;
`ifdef CLK_DIV_ODD_DUTY_EN
  localparam bit ODD_DUTY = 1'b1;
`else
  localparam bit ODD_DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             clk_out;
  logic             tick;
  logic             locked;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_prog #(.WIDTH(WIDTH), .DEF_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .clk_out  (clk_out),
    .tick     (tick),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
  } period_t;

  period_t periods[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected high time in half-cycles for ratio n.
  function automatic int exp_hi(input int n);
    if (ODD_DUTY && ((n % 2) == 1)) return n;
    return 2 * (n / 2);
  endfunction

  // Period monitor: rise-to-rise length in clk cycles, high time in half-cycles.
  bit m_in_per   = 1'b0;
  bit m_prev_out = 1'b0;
  bit m_prev_ack = 1'b0;
  int m_per      = 0;
  int m_hi       = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      check_eq("tick_on_rise", int'(tick), int'(clk_out && !m_prev_out));
      check_eq("ack_single_cycle", int'(div_ack && m_prev_ack), 0);
      if (!rst || !en) begin
        m_in_per = 1'b0;
      end else if (clk_out && !m_prev_out) begin
        if (m_in_per) periods.push_back('{m_per, m_hi});
        m_in_per = 1'b1;
        m_per    = 0;
        m_hi     = 0;
      end
      if (m_in_per) begin
        m_per++;
        m_hi += int'(clk_out);
      end
      m_prev_out = clk_out;
      m_prev_ack = div_ack;
      @(negedge clk); #1;
      if (m_in_per) m_hi += int'(clk_out);
    end
  end

  logic lk1 = 1'b0;
  logic lk2 = 1'b0;

  task automatic cyc();
    lk2 = lk1;
    lk1 = locked;
    @(posedge clk); #3;
  endtask

  task automatic wait_push(input int n, input string tag);
    int guard = 0;
    while ((periods.size() < n) && (guard < 1000)) begin
      cyc();
      guard++;
    end
    if (periods.size() < n) check_eq({tag, "_timeout"}, periods.size(), n);
  endtask

  task automatic check_period(input int idx, input int n, input string tag);
    if (idx < periods.size()) begin
      check_eq({tag, "_per"}, periods[idx].per, n);
      check_eq({tag, "_hi"}, periods[idx].hi, exp_hi(n));
    end else begin
      check_eq({tag, "_missing"}, periods.size(), idx + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, v, v2, eff, npre, j, lat;
    bit dbl;

    rst      = 1'b1;
    en       = 1'b1;
    div_val  = '0;
    div_load = 1'b0;
    #1 rst = 1'b0;
    repeat (3) cyc();
    check_eq("rst_clk_out", int'(clk_out), 0);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_ack", int'(div_ack), 0);

    rst = 1'b1;
    cyc();
    check_eq("en_lat_clk_low", int'(clk_out), 0);
    check_eq("en_lat_tick_low", int'(tick), 0);
    cyc();
    check_eq("en_lat_clk_high", int'(clk_out), 1);
    check_eq("en_lat_tick_high", int'(tick), 1);
    cyc();
    cyc();
    check_eq("first_lock_early", int'(locked), 0);
    cyc();
    check_eq("first_lock", int'(locked), 1);

    cur = 4;
    for (int it = 0; it < 24; it++) begin
      periods.delete();
      wait_push(2, "steady");
      check_period(0, cur, "steady0");
      check_period(1, cur, "steady1");
      check_eq("steady_locked", int'(locked), 1);

      v   = (it == 0) ? 6 : (it == 1) ? 1 : (it == 2) ? 5 : int'($urandom_range(0, 20));
      eff = (v < 2) ? 2 : v;
      dbl = (it >= 3) && ($urandom_range(0, 2) == 0);
      // Keep the capture edge off the period boundary.
      j = int'($urandom_range(0, cur - 1));
      if (((j + 2) % cur) == 0) j = (j + 1) % cur;
      repeat (j) cyc();

      div_val  = WIDTH'(v);
      div_load = 1'b1;
      lat      = 0;
      do begin
        cyc();
        lat++;
      end while (!div_ack && (lat < 50));
      check_eq("ack_latency", lat, 1);
      check_eq("lock_drop", int'(locked), 0);
      npre = periods.size();

      if (dbl) begin
        v2      = int'($urandom_range(2, 20));
        div_val = WIDTH'(v2);
        lat     = 0;
        do begin
          cyc();
          lat++;
        end while (!div_ack && (lat < 1000));
        check_eq("dbl_ack_after_commit", periods.size(), npre + 1);
        div_load = 1'b0;
        wait_push(npre + 3, "dbl");
        check_period(npre,     cur, "dbl_old");
        check_period(npre + 1, eff, "dbl_first");
        check_period(npre + 2, v2,  "dbl_second");
        cur = v2;
      end else begin
        div_load = 1'b0;
        wait_push(npre + 1, "commit");
        check_eq("lock_low_after_commit", int'(locked), 0);
        wait_push(npre + 2, "newratio");
        check_eq("lock_rise_edge", int'(lk1), 1);
        check_eq("lock_not_early", int'(lk2), 0);
        check_period(npre,     cur, "old_period");
        check_period(npre + 1, eff, "new_period");
        cur = eff;
      end
    end

    periods.delete();
    wait_push(1, "pre_drop");
    check_eq("high_before_drop", int'(clk_out), 1);
    en = 1'b0;
    cyc();
    check_eq("drop_clk_low", int'(clk_out), 0);
    check_eq("drop_unlocked", int'(locked), 0);
    check_eq("drop_tick_low", int'(tick), 0);
    repeat (3) cyc();
    check_eq("idle_clk_low", int'(clk_out), 0);
    en = 1'b1;
    periods.delete();
    wait_push(2, "reenable");
    check_period(0, cur, "reenable0");
    check_period(1, cur, "reenable1");
    check_eq("reenable_locked", int'(locked), 1);

    periods.delete();
    wait_push(1, "pre_rst");
    div_val  = (cur == 9) ? 8'd7 : 8'd9;
    div_load = 1'b1;
    lat      = 0;
    do begin
      cyc();
      lat++;
    end while (!div_ack && (lat < 50));
    div_load = 1'b0;
    check_eq("pend_ack_seen", int'(div_ack), 1);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_async_clk_out", int'(clk_out), 0);
    check_eq("rst_async_ack", int'(div_ack), 0);
    check_eq("rst_async_locked", int'(locked), 0);
    check_eq("rst_async_tick", int'(tick), 0);
    cyc();
    rst = 1'b1;
    periods.delete();
    wait_push(2, "post_rst");
    check_period(0, 4, "post_rst0");
    check_period(1, 4, "post_rst1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
